// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared types for the ping-pong frame buffer
package pingpong_pkg;

    // Read FSM encoding kept as plain constants so older code can compare raw bits.
    typedef logic [1:0] rd_state_t;
    localparam rd_state_t RD_IDLE   = 2'd0;
    localparam rd_state_t RD_FETCH  = 2'd1;
    localparam rd_state_t RD_STREAM = 2'd2;

    // Selects one of the two frame banks.
    typedef logic bank_idx_t;

endpackage

// File: rtl/pingpong_bank.sv
// rtl/pingpong_bank.sv - one frame bank: simple dual-port RAM, 1-cycle synchronous read
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr, rdata : read port; rdata updates the cycle after re and holds otherwise
module pingpong_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is never cleared; stale contents stay hidden behind bank_full.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Holding rdata while re is low keeps the output word stable during stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pingpong_buffer_stream.sv
// rtl/pingpong_buffer_stream.sv - two-bank ping-pong frame buffer with valid/ready streams
//   clk, rst_n          : clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_data : producer word stream, DEPTH words per frame
//   rd_valid/rd_ready/rd_data/rd_last : consumer frame stream, rd_last on word DEPTH-1
//   bank_full[1:0]      : bank i holds a complete unread frame
//   drop_cnt[15:0]      : frames discarded while both banks were full (PINGPONG_DROP_EN only)
//   Macro PINGPONG_DROP_EN: never backpressure; drop whole frames that find no free bank.
module pingpong_buffer_stream
    import pingpong_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
`ifdef PINGPONG_DROP_EN
    output logic [15:0]       drop_cnt,
`endif
    output logic [1:0]        bank_full
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bank_idx_t         wsel;
    bank_idx_t         rsel;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_raddr;
    rd_state_t         rd_state;
    logic              wr_fire;
    logic              wr_we;
    logic              rd_fire;
    logic              rd_done;
    logic              rd_re;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic [1:0]        bank_we;
    logic [1:0]        bank_re;
    logic [DATA_W-1:0] bank_rdata [2];

`ifdef PINGPONG_DROP_EN
    logic drop_q;
    logic frame_drop;

    // The drop decision is made on word 0 and then holds for the rest of the frame.
    assign wr_ready   = 1'b1;
    assign frame_drop = (wr_addr == '0) ? bank_full[wsel] : drop_q;
    assign wr_fire    = rst_n && wr_valid;
    assign wr_we      = wr_fire && !frame_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q   <= 1'b0;
            drop_cnt <= '0;
        end else if (wr_fire) begin
            drop_q <= frame_drop && (wr_addr != LAST_ADDR);
            if (frame_drop && (wr_addr == LAST_ADDR) && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`else
    // Gated by rst_n so the producer sees no space while reset is held.
    assign wr_ready = rst_n && !bank_full[wsel];
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_we    = wr_fire;
`endif

    assign rd_valid = (rd_state == RD_STREAM);
    assign rd_last  = rd_valid && (rd_addr == LAST_ADDR);
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_done  = rd_fire && rd_last;

    // Prefetch the next word only when the current one is taken.
    assign rd_re    = (rd_state == RD_FETCH) || (rd_fire && !rd_last);
    assign rd_raddr = (rd_state == RD_FETCH) ? '0 : rd_addr + 1'b1;

    // Set and clear always target different banks, so both apply on one edge.
    assign full_set = (wr_we && (wr_addr == LAST_ADDR)) ? (2'b01 << wsel) : 2'b00;
    assign full_clr = rd_done ? (2'b01 << rsel) : 2'b00;

    assign rd_data  = rd_valid ? bank_rdata[rsel] : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = wr_we && (wsel == bank_idx_t'(b));
        assign bank_re[b] = rd_re && (rsel == bank_idx_t'(b));

        pingpong_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (bank_we[b]),
            .waddr  (wr_addr),
            .wdata  (wr_data),
            .re     (bank_re[b]),
            .raddr  (rd_raddr),
            .rdata  (bank_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            bank_full <= 2'b00;
            rd_state  <= RD_IDLE;
        end else begin
            if (wr_fire) begin
                wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
                if (wr_we && (wr_addr == LAST_ADDR)) begin
                    wsel <= ~wsel;
                end
            end

            bank_full <= (bank_full & ~full_clr) | full_set;

            case (rd_state)
                RD_IDLE: begin
                    rd_addr <= '0;
                    if (bank_full[rsel]) begin
                        rd_state <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    rd_addr  <= '0;
                    rd_state <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (rd_fire) begin
                        if (rd_last) begin
                            rsel     <= ~rsel;
                            rd_state <= RD_IDLE;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pingpong_buffer_stream.sv
// tb/tb_pingpong_buffer_stream.sv - self-checking bench for pingpong_buffer_stream
module tb_pingpong_buffer_stream;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       rd_ready = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       rd_valid;
    logic       rd_last;
    logic [7:0] rd_data;
    logic [1:0] bank_full;
`ifdef PINGPONG_DROP_EN
    logic [15:0] drop_cnt;
`endif

    pingpong_buffer_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
`ifdef PINGPONG_DROP_EN
        .drop_cnt  (drop_cnt),
`endif
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ecount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ecount++;
        #2;
    endtask

    // Frame-level reference: completed frames wait in order, the reader starts a
    // frame two edges after both the frame is complete and the previous one ended.
    logic [7:0] part[$];
    logic [7:0] fq[$];
    int         cedge[$];
    int         done_edge;
    int         wcnt;
    int         ridx;
    bit         streaming;
    bit         rbank;
    bit         part_drop;
    int         mdrop;

    task automatic model_reset();
        part.delete();
        fq.delete();
        cedge.delete();
        done_edge = -10;
        wcnt = 0;
        ridx = 0;
        streaming = 0;
        rbank = 0;
        part_drop = 0;
        mdrop = 0;
    endtask

    function automatic bit exp_ready();
`ifdef PINGPONG_DROP_EN
        return 1'b1;
`else
        return cedge.size() < 2;
`endif
    endfunction

    function automatic logic [1:0] exp_full();
        if (cedge.size() == 0) return 2'b00;
        if (cedge.size() == 1) return rbank ? 2'b10 : 2'b01;
        return 2'b11;
    endfunction

    task automatic cycle(input bit wv, input logic [7:0] wd, input bit rr);
        bit er;
        if (!streaming && cedge.size() > 0 && ecount >= cedge[0] + 2 && ecount >= done_edge + 2) begin
            streaming = 1;
            ridx = 0;
        end
        er = exp_ready();
        check("wr_ready", 32'(wr_ready), 32'(er));
        check("bank_full", 32'(bank_full), 32'(exp_full()));
        check("rd_valid", 32'(rd_valid), 32'(streaming));
        if (streaming) begin
            check("rd_data", 32'(rd_data), 32'(fq[ridx]));
            check("rd_last", 32'(rd_last), 32'(ridx == DEPTH - 1));
        end else begin
            check("rd_last_idle", 32'(rd_last), 32'(0));
        end
`ifdef PINGPONG_DROP_EN
        check("drop_cnt", 32'(drop_cnt), 32'(mdrop));
`endif
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        if (wv && er) begin
`ifdef PINGPONG_DROP_EN
            if (wcnt == 0) part_drop = (cedge.size() == 2);
`endif
            if (!part_drop) part.push_back(wd);
            wcnt++;
            if (wcnt == DEPTH) begin
                wcnt = 0;
                if (part_drop) begin
                    if (mdrop < 65535) mdrop++;
                end else begin
                    fq = {fq, part};
                    part.delete();
                    cedge.push_back(ecount + 1);
                end
            end
        end
        if (streaming && rr) begin
            if (ridx == DEPTH - 1) begin
                repeat (DEPTH) void'(fq.pop_front());
                void'(cedge.pop_front());
                rbank = ~rbank;
                streaming = 0;
                done_edge = ecount + 1;
            end else begin
                ridx++;
            end
        end
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        tick();
`ifdef PINGPONG_DROP_EN
        check("reset_wr_ready", 32'(wr_ready), 32'(1));
`else
        check("reset_wr_ready", 32'(wr_ready), 32'(0));
`endif
        check("reset_rd_valid", 32'(rd_valid), 32'(0));
        check("reset_rd_last", 32'(rd_last), 32'(0));
        check("reset_rd_data", 32'(rd_data), 32'(0));
        check("reset_bank_full", 32'(bank_full), 32'(0));
        model_reset();
        rst_n = 1'b1;
        #1;
        check("release_wr_ready", 32'(wr_ready), 32'(1));
    endtask

    typedef struct {
        bit         wv;
        logic [7:0] wd;
        bit         rr;
        bit         e_ready;
        bit         e_valid;
        logic [7:0] e_data;
        bit         e_last;
        logic [1:0] e_full;
    } vec_t;

    vec_t tbl [18];

    initial begin
        // One frame written back to back, streamed out with rd_ready held high.
        for (int r = 0; r < 18; r++) begin
            tbl[r].wv      = (r < 8);
            tbl[r].wd      = 8'(r);
            tbl[r].rr      = 1'b1;
            tbl[r].e_ready = 1'b1;
            tbl[r].e_valid = (r >= 9) && (r <= 16);
            tbl[r].e_data  = 8'(r - 9);
            tbl[r].e_last  = (r == 16);
            tbl[r].e_full  = (r >= 7 && r <= 16) ? 2'b01 : 2'b00;
        end

        do_reset();

        for (int r = 0; r < 18; r++) begin
            wr_valid = tbl[r].wv;
            wr_data  = tbl[r].wd;
            rd_ready = tbl[r].rr;
            tick();
            check($sformatf("tbl%0d_wr_ready", r), 32'(wr_ready), 32'(tbl[r].e_ready));
            check($sformatf("tbl%0d_rd_valid", r), 32'(rd_valid), 32'(tbl[r].e_valid));
            check($sformatf("tbl%0d_rd_last", r), 32'(rd_last), 32'(tbl[r].e_last));
            check($sformatf("tbl%0d_bank_full", r), 32'(bank_full), 32'(tbl[r].e_full));
            if (tbl[r].e_valid) begin
                check($sformatf("tbl%0d_rd_data", r), 32'(rd_data), 32'(tbl[r].e_data));
            end
        end

        // Both banks full: word 17 stalls until the reader finishes a frame.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 5; i++) cycle(1, 8'h50, 0);
`ifndef PINGPONG_DROP_EN
        check("both_full_ready", 32'(wr_ready), 32'(0));
        check("both_full_banks", 32'(bank_full), 32'(2'b11));
`endif
        for (int i = 0; i < 14; i++) cycle(1, 8'h50, 1);
        for (int i = 0; i < 30; i++) cycle(0, 8'h00, 1);
        check("stall_drain_banks", 32'(bank_full), 32'(2'b00));

        // Reader stalls every other cycle inside a frame.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 8'(8'hA0 + i), 0);
        for (int i = 0; i < 30; i++) cycle(0, 8'h00, i[0]);

        // Reset after a partial frame: only the fresh frame comes out.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'hC0 + i), 1);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 8'(8'h10 + i), 1);
        for (int i = 0; i < 14; i++) cycle(0, 8'h00, 1);
        check("after_reset_drain", 32'(bank_full), 32'(2'b00));

`ifdef PINGPONG_DROP_EN
        // Three frames with no reader: the third is discarded.
        do_reset();
        for (int i = 0; i < 24; i++) cycle(1, 8'(i), 0);
        check("drop_cnt_one", 32'(drop_cnt), 32'(1));
        for (int i = 0; i < 30; i++) cycle(0, 8'h00, 1);
`endif

        // Randomized traffic against the frame-level model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 10) < 7);
        end
        for (int i = 0; i < 40; i++) cycle(0, 8'h00, 1);
        check("random_drain", 32'(bank_full), 32'(2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
